// File: rtl/mskaes_share_loader.sv
// Input staging for the masked AES core: assembles a W-bit stream of shares into
// plaintext and key sharings, offers them on the core handshake, then wipes them.
module mskaes_share_loader #(
  parameter int d = 2,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
  output logic [128*d-1:0]   sh_plaintext,
  output logic [128*d-1:0]   sh_key,
  output logic               core_valid_in,
  input  logic               core_ready,
  output logic               err
);

  localparam int N    = 256 * d / W;
  localparam int HALF = N / 2;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_OFFER,
    ST_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [N-1:0][W-1:0]   data_q;
  logic [CW-1:0]         cnt_q;
  logic                  accept;
  logic                  last_word;
  logic                  wipe;
  logic                  write;

  assign accept    = in_valid && in_ready;
  assign last_word = (cnt_q == CW'(N - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    wipe    = 1'b0;
    write   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (in_last != last_word) begin
            state_d = ST_ERROR;
            wipe    = 1'b1;
          end else begin
            write = 1'b1;
            if (last_word) state_d = ST_OFFER;
          end
        end
      end
      ST_OFFER: begin
        if (core_ready) begin
          state_d = ST_LOAD;
          wipe    = 1'b1;
        end
      end
      ST_ERROR: ;
      default: begin
        state_d = ST_LOAD;
        wipe    = 1'b1;
      end
    endcase
    // Abort wins over any stream word; a coincident core handshake still completes.
    if (clear) begin
      state_d = ST_LOAD;
      wipe    = 1'b1;
      write   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!nrst) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: the share buffer is reset as well, so no secret share survives a reset.
    if (!nrst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (wipe) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (write) begin
      data_q[cnt_q] <= in_data;
      cnt_q         <= last_word ? '0 : cnt_q + CW'(1);
    end
  end

  assign in_ready      = (state_q == ST_LOAD);
  assign core_valid_in = (state_q == ST_OFFER);
  assign err           = (state_q == ST_ERROR);

  // Partial loads are gated off so the core's muxes only ever see complete sharings.
  assign sh_plaintext = core_valid_in ? data_q[HALF-1:0] : '0;
  assign sh_key       = core_valid_in ? data_q[N-1:HALF] : '0;

endmodule
